// File: rtl/mmio_avst_arbiter.sv
// Round-robin arbiter that lets two MMIO AVST requesters share one downstream CSR channel.
// It limits the number of reads in flight and sends each in-order read response back to the port that issued it.
module mmio_avst_arbiter #(
  parameter int AVMM_ADDR_WIDTH = 16,
  parameter int AVMM_DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                     clk,
  input  logic                                     SoftReset,
  input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] s0_data,
  input  logic                                     s0_valid,
  output logic                                     s0_ready,
  output logic [AVMM_DATA_WIDTH-1:0]               s0_rsp_data,
  output logic                                     s0_rsp_valid,
  input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] s1_data,
  input  logic                                     s1_valid,
  output logic                                     s1_ready,
  output logic [AVMM_DATA_WIDTH-1:0]               s1_rsp_data,
  output logic                                     s1_rsp_valid,
  output logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] m_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  input  logic [AVMM_DATA_WIDTH-1:0]               m_rsp_data,
  input  logic                                     m_rsp_valid,
  output logic                                     rsp_err
);

  localparam int REQ_W = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 2;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [REQ_W-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_owner [MAX_OUTSTANDING];
  logic             r_s0_rsp_valid;
  logic             r_s1_rsp_valid;
  logic [AVMM_DATA_WIDTH-1:0] r_rsp_data;
  logic             r_err;

  logic             w_load_en;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_push;
  logic             w_pop;
  logic             w_pop_id;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_load_en = !r_m_valid || m_ready;
  // The read limit is checked against the registered count, so a response in this cycle frees a slot only in the next cycle.
  assign w_elig0 = s0_valid && (!s0_data[REQ_W-1] || (r_cnt < CNT_MAX));
  assign w_elig1 = s1_valid && (!s1_data[REQ_W-1] || (r_cnt < CNT_MAX));

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!SoftReset && w_load_en) begin
      if (w_elig0 && w_elig1) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = w_elig0;
        w_grant1 = w_elig1;
      end
    end
  end

  assign w_push   = (w_grant0 && s0_data[REQ_W-1]) || (w_grant1 && s1_data[REQ_W-1]);
  assign w_pop    = m_rsp_valid && (r_cnt != '0);
  assign w_pop_id = r_owner[r_rd_ptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      r_m_valid      <= 1'b0;
      r_last_grant   <= 1'b1;
      r_cnt          <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_s0_rsp_valid <= 1'b0;
      r_s1_rsp_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      if (w_load_en) begin
        r_m_valid <= w_grant0 || w_grant1;
        if (w_grant0) begin
          r_m_data <= s0_data;
        end else if (w_grant1) begin
          r_m_data <= s1_data;
        end
      end
      if (w_grant0 || w_grant1) begin
        r_last_grant <= w_grant1;
      end
      r_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_s0_rsp_valid <= w_pop && !w_pop_id;
      r_s1_rsp_valid <= w_pop && w_pop_id;
      if (m_rsp_valid && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
    r_rsp_data <= m_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_owner[r_wr_ptr] <= w_grant1;
    end
  end

  assign s0_ready     = w_grant0;
  assign s1_ready     = w_grant1;
  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign s0_rsp_valid = r_s0_rsp_valid;
  assign s1_rsp_valid = r_s1_rsp_valid;
  assign s0_rsp_data  = r_rsp_data;
  assign s1_rsp_data  = r_rsp_data;
  assign rsp_err      = r_err;

endmodule

// File: tb/tb_mmio_avst_arbiter.sv
// Bench for mmio_avst_arbiter: directed scenarios followed by randomized traffic.
// The randomized traffic is checked against a queue-based model of ownership and round-robin order.
module tb_mmio_avst_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 64;
  localparam int RW   = AW + DW + 2;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          SoftReset = 1'b1;
  logic [RW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [DW-1:0] s0_rsp_data, s1_rsp_data;
  logic          s0_rsp_valid, s1_rsp_valid;
  logic [RW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic          m_rsp_valid = 1'b0;
  logic          rsp_err;

  int n_vec = 0;
  int n_err = 0;

  mmio_avst_arbiter #(
    .AVMM_ADDR_WIDTH(AW),
    .AVMM_DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .SoftReset(SoftReset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_rsp_data(s0_rsp_data), .s0_rsp_valid(s0_rsp_valid),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_rsp_data(s1_rsp_data), .s1_rsp_valid(s1_rsp_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_rsp_data(m_rsp_data), .m_rsp_valid(m_rsp_valid),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model state: the downstream output slot, owner queue, round-robin pointer, and sticky error
  bit            mv = 1'b0;
  logic [RW-1:0] md = '0;
  int            last = 1;
  int            q[$];
  bit            err = 1'b0;
  bit            rv0 = 1'b0, rv1 = 1'b0;
  logic [DW-1:0] rdat = '0;

  function automatic logic [RW-1:0] mk_req(input bit rd, input bit b32, input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
    return {rd, b32, a, d};
  endfunction

  function automatic logic [RW-1:0] rand_req();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    return mk_req(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 65535)), d);
  endfunction

  function automatic void exp_grants(output bit g0, output bit g1);
    bit e0, e1;
    logic [RW-1:0] d0, d1;
    d0 = s0_data;
    d1 = s1_data;
    e0 = s0_valid && (!d0[RW-1] || q.size() < MAXO);
    e1 = s1_valid && (!d1[RW-1] || q.size() < MAXO);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!SoftReset && (!mv || m_ready)) begin
      if (e0 && e1) begin
        g0 = (last == 1);
        g1 = (last == 0);
      end else begin
        g0 = e0;
        g1 = e1;
      end
    end
  endfunction

  task automatic mdl_commit();
    bit g0, g1;
    int o;
    logic [RW-1:0] d0, d1;
    d0 = s0_data;
    d1 = s1_data;
    exp_grants(g0, g1);
    if (SoftReset) begin
      mv = 1'b0; last = 1; q.delete(); err = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    end else begin
      rv0 = 1'b0; rv1 = 1'b0;
      if (m_rsp_valid) begin
        if (q.size() == 0) begin
          err = 1'b1;
        end else begin
          o = q.pop_front();
          rv0 = (o == 0);
          rv1 = (o == 1);
          rdat = m_rsp_data;
        end
      end
      if (!mv || m_ready) begin
        mv = g0 || g1;
        if (g0) md = d0;
        else if (g1) md = d1;
      end
      if (g0) begin last = 0; if (d0[RW-1]) q.push_back(0); end
      if (g1) begin last = 1; if (d1[RW-1]) q.push_back(1); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_commit();
    #1;
  endtask

  task automatic do_reset();
    SoftReset = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; m_rsp_valid = 1'b0; m_ready = 1'b1;
    tick();
    SoftReset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0 || s0_rsp_valid !== 1'b0 ||
        s1_rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got mv=%b r0=%b r1=%b v0=%b v1=%b err=%b want all 0",
               m_valid, s0_ready, s1_ready, s0_rsp_valid, s1_rsp_valid, rsp_err);
    end
  endtask

  task automatic test_write_p0();
    logic [RW-1:0] req;
    do_reset();
    req = mk_req(1'b0, 1'b0, 16'h0010, 64'hDEAD_BEEF_0000_0001);
    s0_data = req; s0_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      n_err++; $display("FAIL wr_ready: got r0=%b r1=%b want 1 0", s0_ready, s1_ready);
    end
    tick();
    s0_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b1 || m_data !== req) begin
      n_err++; $display("FAIL wr_out: got mv=%b md=%h want 1 %h", m_valid, m_data, req);
    end
    n_vec++;
    if (s0_rsp_valid !== 1'b0 || s1_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_norsp: got v0=%b v1=%b want 0 0", s0_rsp_valid, s1_rsp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int n0, n1;
    n0 = 0; n1 = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      s0_data = mk_req(1'b0, 1'b0, AW'(c), DW'(c)); s0_valid = 1'b1;
      s1_data = mk_req(1'b0, 1'b1, AW'(c + 100), DW'(c + 100)); s1_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (s0_ready !== bit'(c % 2 == 0) || s1_ready !== bit'(c % 2 == 1)) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got r0=%b r1=%b want %b %b", c, s0_ready, s1_ready,
                 bit'(c % 2 == 0), bit'(c % 2 == 1));
      end
      if (s0_ready === 1'b1) n0++;
      if (s1_ready === 1'b1) n1++;
      tick();
    end
    n_vec++;
    if (n0 != 4 || n1 != 4) begin
      n_err++; $display("FAIL rr_count: got %0d/%0d want 4/4", n0, n1);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_interleaved_reads();
    bit e0, e1, ev0, ev1;
    logic [DW-1:0] ed;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s0_valid = (c == 0 || c == 2);
      s1_valid = (c == 1);
      s0_data = mk_req(1'b1, 1'b0, AW'(16'h100 + c), '0);
      s1_data = mk_req(1'b1, 1'b1, AW'(16'h200 + c), '0);
      m_rsp_valid = (c >= 5 && c <= 7);
      m_rsp_data = DW'(c - 4);
      e0 = (c == 0 || c == 2); e1 = (c == 1);
      ev0 = (c == 6 || c == 8); ev1 = (c == 7);
      ed = (c == 6) ? 64'h1 : (c == 7) ? 64'h2 : 64'h3;
      @(negedge clk);
      n_vec++;
      if (s0_ready !== e0 || s1_ready !== e1) begin
        n_err++; $display("FAIL ilv_ready%0d: got %b %b want %b %b", c, s0_ready, s1_ready, e0, e1);
      end
      n_vec++;
      if (s0_rsp_valid !== ev0 || s1_rsp_valid !== ev1 ||
          (ev0 && s0_rsp_data !== ed) || (ev1 && s1_rsp_data !== ed)) begin
        n_err++;
        $display("FAIL ilv_rsp%0d: got v0=%b d0=%h v1=%b d1=%h want %b %b data %h", c,
                 s0_rsp_valid, s0_rsp_data, s1_rsp_valid, s1_rsp_data, ev0, ev1, ed);
      end
      tick();
    end
    m_rsp_valid = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    bit e0, e1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s1_valid = 1'b1;
      s1_data = mk_req(1'b1, 1'b0, AW'(c), '0);
      s0_valid = (c == 5);
      s0_data = mk_req(1'b0, 1'b0, 16'h0040, 64'hCAFE);
      m_rsp_valid = (c == 7);
      m_rsp_data = 64'h55;
      e1 = (c < 4) || (c == 8);
      e0 = (c == 5);
      @(negedge clk);
      n_vec++;
      if (s0_ready !== e0 || s1_ready !== e1) begin
        n_err++; $display("FAIL lim_ready%0d: got %b %b want %b %b", c, s0_ready, s1_ready, e0, e1);
      end
      if (c == 8) begin
        n_vec++;
        if (s1_rsp_valid !== 1'b1 || s1_rsp_data !== 64'h55 || s0_rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL lim_rsp: got v1=%b d1=%h v0=%b want 1 55 0", s1_rsp_valid, s1_rsp_data, s0_rsp_valid);
        end
      end
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; m_rsp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] da, db;
    do_reset();
    da = mk_req(1'b0, 1'b0, 16'h1111, 64'hA);
    db = mk_req(1'b0, 1'b0, 16'h2222, 64'hB);
    s0_data = da; s1_data = db; s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s0_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_first: got r0=%b want 1", s0_ready);
    end
    tick();
    s0_data = mk_req(1'b0, 1'b0, 16'h3333, 64'hC);
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== da) begin
        n_err++;
        $display("FAIL bp_hold%0d: got r0=%b r1=%b mv=%b md=%h want 0 0 1 %h", c, s0_ready,
                 s1_ready, m_valid, m_data, da);
      end
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got r0=%b r1=%b want 0 1", s0_ready, s1_ready);
    end
    tick();
    s1_valid = 1'b0; s0_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b1 || m_data !== db) begin
      n_err++; $display("FAIL bp_data: got mv=%b md=%h want 1 %h", m_valid, m_data, db);
    end
    tick();
  endtask

  task automatic test_error_reset();
    do_reset();
    m_rsp_valid = 1'b1; m_rsp_data = 64'h77;
    tick();
    m_rsp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rsp_err !== 1'b1 || s0_rsp_valid !== 1'b0 || s1_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL err_stray: got err=%b v0=%b v1=%b want 1 0 0", rsp_err, s0_rsp_valid, s1_rsp_valid);
    end
    for (int c = 0; c < 2; c++) begin
      s0_valid = 1'b1; s0_data = mk_req(1'b1, 1'b0, AW'(c), '0);
      @(negedge clk);
      n_vec++;
      if (s0_ready !== 1'b1) begin
        n_err++; $display("FAIL err_rd%0d: got r0=%b want 1", c, s0_ready);
      end
      tick();
    end
    s0_valid = 1'b0;
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0 || rsp_err !== 1'b0 || s0_rsp_valid !== 1'b0 || s1_rsp_valid !== 1'b0 ||
        s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL err_reset: got mv=%b err=%b v0=%b v1=%b r0=%b r1=%b want all 0",
               m_valid, rsp_err, s0_rsp_valid, s1_rsp_valid, s0_ready, s1_ready);
    end
    m_rsp_valid = 1'b1;
    tick();
    m_rsp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rsp_err !== 1'b1 || s0_rsp_valid !== 1'b0 || s1_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL err_post: got err=%b v0=%b v1=%b want 1 0 0", rsp_err, s0_rsp_valid, s1_rsp_valid);
    end
    tick();
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exp_grants(g0, g1);
      n_vec++;
      if (s0_ready !== g0 || s1_ready !== g1) begin
        n_err++; $display("FAIL rnd_ready%0d: got %b %b want %b %b", c, s0_ready, s1_ready, g0, g1);
      end
      n_vec++;
      if (m_valid !== mv || (mv && m_data !== md)) begin
        n_err++; $display("FAIL rnd_out%0d: got mv=%b md=%h want %b %h", c, m_valid, m_data, mv, md);
      end
      n_vec++;
      if (s0_rsp_valid !== rv0 || s1_rsp_valid !== rv1 ||
          (rv0 && s0_rsp_data !== rdat) || (rv1 && s1_rsp_data !== rdat)) begin
        n_err++;
        $display("FAIL rnd_rsp%0d: got v0=%b d0=%h v1=%b d1=%h want %b %b %h", c, s0_rsp_valid,
                 s0_rsp_data, s1_rsp_valid, s1_rsp_data, rv0, rv1, rdat);
      end
      n_vec++;
      if (rsp_err !== err) begin
        n_err++; $display("FAIL rnd_err%0d: got %b want %b", c, rsp_err, err);
      end
      tick();
      if (SoftReset) begin
        SoftReset = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
      end
      if (g0 || !s0_valid) begin
        s0_valid = ($urandom_range(0, 9) < 7);
        s0_data = rand_req();
      end
      if (g1 || !s1_valid) begin
        s1_valid = ($urandom_range(0, 9) < 7);
        s1_data = rand_req();
      end
      m_ready = ($urandom_range(0, 3) != 0);
      m_rsp_data = {$urandom, $urandom};
      if (q.size() > 0) m_rsp_valid = ($urandom_range(0, 2) == 0);
      else m_rsp_valid = ($urandom_range(0, 299) == 0);
      SoftReset = ($urandom_range(0, 399) == 0);
    end
    SoftReset = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; m_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_round_robin();
    test_interleaved_reads();
    test_outstanding_limit();
    test_backpressure();
    test_error_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_avst_arbiter.md
Name: mmio_avst_arbiter

Overview:
- Shares one MMIO AVST request/response channel between two requesters.
- Port 0 is the host CCI-P MMIO bridge. Port 1 is an internal CSR master, e.g. the debug/scrub sequencer.
- Issues requests to the downstream AVMM CSR converter in round-robin order and caps outstanding reads.
- Downstream returns read responses in order; the block routes each one back to the port that issued the read.

Parameters:
- AVMM_ADDR_WIDTH, 16, byte address width of request field addr.
- AVMM_DATA_WIDTH, 64, write/read data width.
- MAX_OUTSTANDING, 16, maximum reads in flight downstream. Power of 2, range 2..64.

Ports:
- clk  in  1  single clock.
- SoftReset  in  1  synchronous active-high reset.
- s0_data  in  AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+2  port 0 request {is_read, is_32bit, addr, write_data}, MSB first.
- s0_valid  in  1  port 0 request valid.
- s0_ready  out  1  port 0 request accepted this cycle.
- s0_rsp_data  out  AVMM_DATA_WIDTH  port 0 read data.
- s0_rsp_valid  out  1  port 0 read response strobe.
- s1_data, s1_valid, s1_ready, s1_rsp_data, s1_rsp_valid: same widths and meaning for port 1.
- m_data  out  AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+2  downstream request.
- m_valid  out  1  downstream request valid.
- m_ready  in  1  downstream accepts.
- m_rsp_data  in  AVMM_DATA_WIDTH  downstream read data.
- m_rsp_valid  in  1  downstream read response, in request order, never stalled.
- rsp_err  out  1  sticky: a response arrived with no read outstanding.

Behaviour:
- Reset values: m_valid=0, s0_ready=0, s1_ready=0, s0_rsp_valid=0, s1_rsp_valid=0, rsp_err=0, outstanding count=0, owner FIFO empty, last_grant=1 (port 0 wins the first tie). Data outputs are don't-care.
- Output stage:
  - m_data/m_valid is a single register.
  - load_en = !m_valid || m_ready.
  - On a load with no grant, m_valid falls to 0.
- Eligibility:
  - is_read = bit [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1].
  - A write request is always eligible.
  - A read request is eligible only if outstanding < MAX_OUTSTANDING.
  - The limit check uses the registered count. A response in the same cycle does not free a slot until the next cycle.
- Arbitration:
  - Evaluated only when load_en=1.
  - If exactly one port is valid and eligible, it wins.
  - If both are, the port not equal to last_grant wins.
  - sN_ready is combinational: grant to N this cycle. The accepted request is on m_data the next cycle.
  - last_grant updates only on an actual grant.
  - An ineligible read holds its port. The other port may still be granted; there is no reordering within a port.
- Read tracking:
  - On a granted read, push the owner id (0/1) into the owner FIFO (depth MAX_OUTSTANDING) and increment outstanding.
  - On m_rsp_valid, pop the FIFO and decrement.
  - Grant-read and response in the same cycle: count unchanged, push and pop both occur.
  - The FIFO cannot overflow because it is bounded by the limit.
- Response routing:
  - Latency is 1 cycle: sN_rsp_valid/sN_rsp_data are registered copies of m_rsp_valid/m_rsp_data steered by the popped owner.
  - At most one sN_rsp_valid is high per cycle.
- Unexpected response: m_rsp_valid while outstanding=0. The response is dropped, no sN_rsp_valid is asserted, the count stays at 0 (no underflow), and rsp_err is set until SoftReset.
- Writes generate no response and are not counted.
- Reset mid-operation:
  - All state clears in the reset cycle and any pending m_valid is dropped.
  - Responses to pre-reset reads that arrive afterwards set rsp_err.
  - Upstream sources are reset by the same SoftReset.

Test Plan:
- Port 0 write only, m_ready=1: s0_valid for 1 cycle with addr 0x0010, data 0xDEAD_BEEF_0000_0001 -> s0_ready=1 that cycle; m_valid=1 next cycle with identical m_data; no rsp_valid, count stays 0.
- Both ports continuously valid with writes, m_ready=1 -> grants alternate 0,1,0,1 starting with port 0; 8 cycles give 4 grants each.
- Interleaved reads: p0 read A, p1 read B, p0 read C. Downstream returns 0x1, 0x2, 0x3 with 5-cycle latency -> s0_rsp gets 0x1 then 0x3, s1_rsp gets 0x2, each 1 cycle after its m_rsp_valid.
- Outstanding limit: MAX_OUTSTANDING=4, p1 issues 6 reads with no responses -> 4 granted, s1_ready=0 afterwards. A p0 write in the meantime is still granted. One response allows exactly one more p1 read the following cycle.
- Backpressure: m_ready=0 for 10 cycles with both ports valid -> m_data held stable, s0_ready=s1_ready=0; the first cycle with m_ready=1 grants the next port in round-robin order.
- Error/reset: m_rsp_valid with count=0 -> rsp_err=1, no sN_rsp_valid. Then 2 reads outstanding, assert SoftReset 1 cycle -> all outputs at reset values and count=0; a subsequent stray response sets rsp_err again.
